// File: rtl/valve_sequencer_if.sv
// Instruction-memory read port between the valve sequencer and its program store.
// Synchronous memory: imem_data is valid the cycle after imem_en.
interface valve_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [12:0]       imem_data;

  modport master (output imem_en, output imem_addr, input  imem_data);
  modport slave  (input  imem_en, input  imem_addr, output imem_data);
endinterface

// File: rtl/valve_sequencer.sv
// Program sequencer for the microfluidic valve controller: fetches and executes
// Set/Unset, Delay, Halt and NOP instructions and holds the 16-valve drive register.
module valve_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  valve_sequencer_if.master      imem,
  output logic [15:0]            valves,
  output logic [ADDR_W-1:0]      pc,
  output logic                   busy,
  output logic                   delay_active,
  output logic                   halted
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t            state, state_d;
  logic [15:0]       valves_d;
  logic [ADDR_W-1:0] pc_d, pc_inc;
  logic [5:0]        dly_cnt, dly_cnt_d;
  logic [9:0]        unit_cnt, unit_cnt_d;
  logic [9:0]        unit_max, unit_max_d;
  logic [PW-1:0]     presc, presc_d;
  logic              imem_en_d, busy_d, delay_active_d, halted_d;

  logic [2:0]  op;
  logic [5:0]  d_count;
  logic [2:0]  d_unit;
  logic        d_debug;
  logic [9:0]  d_mult_m1;

  assign op      = imem.imem_data[12:10];
  assign d_count = imem.imem_data[9:4];
  assign d_unit  = imem.imem_data[3:1];
  assign d_debug = imem.imem_data[0];
  assign pc_inc  = pc + 1'b1;

  // Unit counter limit is stored as M-1 so a full millisecond group ends on equality.
  always_comb begin
    d_mult_m1 = '0;
    if (!d_debug) begin
      case (d_unit)
        3'd0:    d_mult_m1 = 10'd0;
        3'd1:    d_mult_m1 = 10'd9;
        3'd2:    d_mult_m1 = 10'd99;
        default: d_mult_m1 = 10'd999;
      endcase
    end
  end

  always_comb begin
    state_d    = state;
    valves_d   = valves;
    pc_d       = pc;
    dly_cnt_d  = dly_cnt;
    unit_cnt_d = unit_cnt;
    unit_max_d = unit_max;
    presc_d    = presc;

    if (stop) begin
      state_d    = S_IDLE;
      valves_d   = '0;
      pc_d       = '0;
      dly_cnt_d  = '0;
      unit_cnt_d = '0;
      unit_max_d = '0;
      presc_d    = '0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = '0;
          end
        end
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          case (op)
            3'b001: begin
              valves_d[imem.imem_data[9:6]] = imem.imem_data[1];
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
            3'b010: begin
              if (d_count == 6'd0) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end else begin
                dly_cnt_d  = d_count;
                unit_cnt_d = '0;
                unit_max_d = d_mult_m1;
                presc_d    = '0;
                state_d    = S_WAIT;
              end
            end
            3'b011: begin
              valves_d = '0;
              state_d  = S_HALTED;
            end
            default: begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          endcase
        end
        S_WAIT: begin
          if (presc == PRESC_LAST) begin
            presc_d = '0;
            if (unit_cnt == unit_max) begin
              unit_cnt_d = '0;
              if (dly_cnt == 6'd1) begin
                dly_cnt_d = '0;
                pc_d      = pc_inc;
                state_d   = S_FETCH;
              end else begin
                dly_cnt_d = dly_cnt - 1'b1;
              end
            end else begin
              unit_cnt_d = unit_cnt + 1'b1;
            end
          end else begin
            presc_d = presc + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    imem_en_d      = (state_d == S_FETCH);
    busy_d         = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WAIT);
    delay_active_d = (state_d == S_WAIT);
    halted_d       = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      valves         <= '0;
      pc             <= '0;
      dly_cnt        <= '0;
      unit_cnt       <= '0;
      unit_max       <= '0;
      presc          <= '0;
      imem.imem_en   <= 1'b0;
      imem.imem_addr <= '0;
      busy           <= 1'b0;
      delay_active   <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_d;
      valves         <= valves_d;
      pc             <= pc_d;
      dly_cnt        <= dly_cnt_d;
      unit_cnt       <= unit_cnt_d;
      unit_max       <= unit_max_d;
      presc          <= presc_d;
      imem.imem_en   <= imem_en_d;
      imem.imem_addr <= pc_d;
      busy           <= busy_d;
      delay_active   <= delay_active_d;
      halted         <= halted_d;
    end
  end

endmodule

// File: tb/tb_valve_sequencer.sv
// Randomized scoreboard bench for valve_sequencer: a program-level interpreter
// predicts every fetch/halt event, a monitor checks them as the DUT presents them.
module tb_valve_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned TD = 4;
  localparam logic [12:0] HALT = 13'h0C00;
  localparam logic [12:0] NOP  = 13'h1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   valves;
  logic [AW-1:0] pc;
  logic          busy, delay_active, halted;

  valve_sequencer_if #(.ADDR_W(AW)) bus ();

  valve_sequencer #(.ADDR_W(AW), .TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .imem         (bus),
    .valves       (valves),
    .pc           (pc),
    .busy         (busy),
    .delay_active (delay_active),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  logic [12:0] mem [16];
  always @(posedge clk) if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr];

  typedef struct {
    bit halt;
    int addr;
    int valves;
    int gap;
    int wait_c;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  sb_on = 1'b0;
  int  cyc = 0;
  int  last_cyc = 0;
  int  da_cnt = 0;
  bit  halt_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk(bit h, int a, int v, int g, int w);
    ev_t e;
    e.halt = h; e.addr = a; e.valves = v; e.gap = g; e.wait_c = w;
    return e;
  endfunction

  // Program-level interpreter: one event per retired instruction.
  task automatic model_prog();
    int p, v, op, ins, cnt, unit, m, w;
    p = 0; v = 0;
    exp_q.push_back(mk(1'b0, 0, 0, 1, 0));
    for (int step = 0; step < 64; step++) begin
      ins = int'(mem[p]);
      op  = (ins >> 10) & 7;
      if (op == 3) begin
        exp_q.push_back(mk(1'b1, p, 0, 2, 0));
        return;
      end
      w = 0;
      if (op == 1) begin
        v = (v & ~(1 << ((ins >> 6) & 15))) | (((ins >> 1) & 1) << ((ins >> 6) & 15));
        v = v & 16'hFFFF;
      end else if (op == 2) begin
        cnt  = (ins >> 4) & 63;
        unit = (ins >> 1) & 7;
        m    = (ins & 1) ? 1 : (unit == 0) ? 1 : (unit == 1) ? 10 : (unit == 2) ? 100 : 1000;
        w    = cnt * m * TD;
      end
      p = (p + 1) % 16;
      exp_q.push_back(mk(1'b0, p, v, 2 + w, w));
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (!sb_on) begin
      last_cyc = cyc;
      da_cnt   = 0;
    end else begin
      if (start) begin
        last_cyc = cyc;
        da_cnt   = 0;
      end
      if (delay_active) da_cnt++;
      if (bus.imem_en || (halted && !halt_prev)) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_unexpected: got event at pc 0x%0h, expected none", pc);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind", bus.imem_en ? 0 : 1, int'(e.halt));
          chk("ev_pc", int'(pc), e.addr);
          if (bus.imem_en) chk("ev_imem_addr", int'(bus.imem_addr), e.addr);
          chk("ev_valves", int'(valves), e.valves);
          chk("ev_gap", cyc - last_cyc, e.gap);
          chk("ev_wait_cycles", da_cnt, e.wait_c);
        end
        last_cyc = cyc;
        da_cnt   = 0;
      end
    end
    halt_prev = halted;
  end

  task automatic fill(input logic [12:0] w);
    for (int i = 0; i < 16; i++) mem[i] = w;
  endtask

  task automatic launch();
    sb_on = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drain(input int budget);
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("sb_drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 sb_on = 1'b0;
  endtask

  task automatic run_prog();
    int budget;
    model_prog();
    budget = 20;
    foreach (exp_q[i]) budget += exp_q[i].gap;
    launch();
    drain(budget);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valves"}, int'(valves), 0);
    chk({tag, "_pc"}, int'(pc), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_delay_active"}, int'(delay_active), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_imem_en"}, int'(bus.imem_en), 0);
    chk({tag, "_imem_addr"}, int'(bus.imem_addr), 0);
  endtask

  task automatic wait_for_delay(input string tag);
    int n = 0;
    while (!delay_active && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, int'(delay_active), 1);
  endtask

  function automatic logic [12:0] rand_ins();
    logic [12:0] r;
    int unsigned k, unit;
    r = 13'($urandom);
    k = $urandom_range(0, 9);
    if (k < 4) begin
      r[12:10] = 3'b001;
    end else if (k < 7) begin
      r[12:10] = 3'b010;
      r[9:4]   = 6'($urandom_range(0, 3));
      unit     = $urandom_range(0, 7);
      r[3:1]   = 3'(unit);
      r[0]     = (unit >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
    end else begin
      case ($urandom_range(0, 4))
        0:       r[12:10] = 3'b000;
        1:       r[12:10] = 3'b100;
        2:       r[12:10] = 3'b101;
        3:       r[12:10] = 3'b110;
        default: r[12:10] = 3'b111;
      endcase
    end
    return r;
  endfunction

  initial begin
    int n;
    #1 chk_all_zero("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    fill(HALT); mem[0] = 13'h0642; mem[1] = HALT;
    run_prog();
    chk("halt_flag", int'(halted), 1);
    chk("halt_pc", int'(pc), 1);
    chk("halt_valves", int'(valves), 0);
    chk("halt_busy", int'(busy), 0);

    fill(HALT); mem[0] = 13'h0832; run_prog();
    fill(HALT); mem[0] = 13'h0833; run_prog();
    fill(HALT); mem[0] = 13'h0802; run_prog();
    fill(HALT); mem[0] = 13'h04C2; mem[1] = 13'h04C0; mem[2] = NOP; run_prog();
    fill(HALT); mem[0] = 13'h04C2; mem[1] = 13'h00CA; mem[2] = 13'h0814; run_prog();
    fill(HALT); mem[0] = 13'h07C2; mem[1] = 13'h081E; run_prog();

    // PC wrap: 16 NOPs, then address 0 is patched to Halt for the second pass.
    fill(NOP);
    exp_q.push_back(mk(1'b0, 0, 0, 1, 0));
    for (int i = 1; i <= 16; i++) exp_q.push_back(mk(1'b0, i % 16, 0, 2, 0));
    exp_q.push_back(mk(1'b1, 0, 0, 2, 0));
    launch();
    n = 0;
    while (!(bus.imem_en && bus.imem_addr == AW'(1)) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wrap_first_fetch1", int'(bus.imem_addr), 1);
    mem[0] = HALT;
    drain(80);

    // stop with simultaneous start in the middle of a delay
    fill(HALT); mem[0] = 13'h0542; mem[1] = 13'h0832;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_for_delay("stop_reach_wait");
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wait_start_ignored_da", int'(delay_active), 1);
    chk("wait_start_ignored_pc", int'(pc), 1);
    chk("wait_valves_held", int'(valves), 16'h0020);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    chk_all_zero("stop");
    repeat (3) @(posedge clk);
    #1 chk("stop_stays_idle", int'(busy), 0);

    fill(HALT); mem[0] = 13'h0442; mem[1] = 13'h0812; run_prog();

    // asynchronous reset during a delay
    fill(HALT); mem[0] = 13'h0542; mem[1] = 13'h0832;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_for_delay("rst_reach_wait");
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = rand_ins();
      mem[$urandom_range(0, 15)] = HALT | 13'($urandom_range(0, 1023));
      run_prog();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
